// File: rtl/reg_dump_streamer_if.sv
// Register-dump stream bundle: one {addr,data,last} beat per valid/ready handshake.
interface reg_dump_streamer_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_last;

  // Producer side: the dump engine drives the beat and watches ready.
  modport master (
    output dump_valid,
    output dump_addr,
    output dump_data,
    output dump_last,
    input  dump_ready
  );

  // Consumer side: receives the beat and drives ready.
  modport slave (
    input  dump_valid,
    input  dump_addr,
    input  dump_data,
    input  dump_last,
    output dump_ready
  );
endinterface

// File: rtl/reg_dump_streamer.sv
// Register-file read-out engine: freezes the pipeline through a stall
// request/acknowledge pair, then reads every register through A1/RD1 and
// streams it as {addr,data,last} beats. Losing the acknowledge mid-dump
// aborts the dump; a partial dump is never resumed.
module reg_dump_streamer #(
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int SKIP_X0 = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 stall_req,
  input  logic                 stall_ack,
  output logic [AW-1:0]        rf_addr,
  input  logic [DW-1:0]        rf_rdata,
  reg_dump_streamer_if.master  dump,
  output logic                 busy,
  output logic                 done,
  output logic                 abort
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_READ  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  localparam logic [AW-1:0] FIRST_IDX = AW'(SKIP_X0);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

  state_t        state_r;
  state_t        state_s;
  logic [AW-1:0] idx_r;
  logic [AW-1:0] idx_s;

  logic          stall_req_r;
  logic          busy_r;
  logic          done_r;
  logic          abort_r;
  logic          valid_r;
  logic [AW-1:0] rf_addr_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] data_r;
  logic          last_r;

  // Next-state and index update; losing the acknowledge outranks a handshake.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_REQ;
          idx_s   = FIRST_IDX;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (stall_ack) begin
          state_s = S_READ;
        end else begin
          state_s = S_REQ;
        end
      end
      S_READ: begin
        if (!stall_ack) begin
          state_s = S_ABORT;
        end else begin
          state_s = S_SEND;
        end
      end
      S_SEND: begin
        if (!stall_ack) begin
          state_s = S_ABORT;
        end else if (dump.dump_ready) begin
          if (last_r) begin
            state_s = S_DONE;
          end else begin
            idx_s   = idx_r + AW'(1);
            state_s = S_READ;
          end
        end else begin
          state_s = S_SEND;
        end
      end
      S_DONE:  state_s = S_IDLE;
      S_ABORT: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State and index register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_IDLE;
      idx_r   <= FIRST_IDX;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Control outputs registered from the upcoming state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_req_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      abort_r     <= 1'b0;
      valid_r     <= 1'b0;
      rf_addr_r   <= {AW{1'b0}};
    end else begin
      stall_req_r <= (state_s == S_REQ) || (state_s == S_READ) || (state_s == S_SEND);
      busy_r      <= (state_s != S_IDLE);
      done_r      <= (state_s == S_DONE);
      abort_r     <= (state_s == S_ABORT);
      valid_r     <= (state_s == S_SEND);
      rf_addr_r   <= ((state_s == S_READ) || (state_s == S_SEND)) ? idx_s : {AW{1'b0}};
    end
  end

  // Capture the beat from RD1 during READ; it is then held through SEND.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_r <= {AW{1'b0}};
      data_r <= {DW{1'b0}};
      last_r <= 1'b0;
    end else if (state_r == S_READ) begin
      addr_r <= idx_r;
      data_r <= rf_rdata;
      last_r <= (idx_r == LAST_IDX);
    end else begin
      addr_r <= addr_r;
      data_r <= data_r;
      last_r <= last_r;
    end
  end

  assign stall_req       = stall_req_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign abort           = abort_r;
  assign rf_addr         = rf_addr_r;
  assign dump.dump_valid = valid_r;
  assign dump.dump_addr  = addr_r;
  assign dump.dump_data  = data_r;
  assign dump.dump_last  = last_r;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Randomized self-checking bench: two instances (x0 included / x0 skipped)
// share one register-file model; a beat queue built from the register
// contents is the reference for the stream, and cycle counts come from the
// READ+SEND-per-beat timing rule.
module tb_reg_dump_streamer;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic          stall_ack;
  logic          ready;
  logic          sel;
  logic [DW-1:0] rf [NREGS];

  logic          start0, start1;
  logic          sr0, sr1, busy0, busy1, done0, done1, abort0, abort1;
  logic [AW-1:0] ra0, ra1;
  logic [DW-1:0] rd0, rd1;

  reg_dump_streamer_if #(.AW(AW), .DW(DW)) if0 ();
  reg_dump_streamer_if #(.AW(AW), .DW(DW)) if1 ();

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign rd0 = rf[ra0];
  assign rd1 = rf[ra1];
  assign if0.dump_ready = ready;
  assign if1.dump_ready = ready;

  reg_dump_streamer #(.NREGS(NREGS), .AW(AW), .DW(DW), .SKIP_X0(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .stall_req(sr0), .stall_ack(stall_ack),
    .rf_addr(ra0), .rf_rdata(rd0), .dump(if0), .busy(busy0), .done(done0), .abort(abort0)
  );

  reg_dump_streamer #(.NREGS(NREGS), .AW(AW), .DW(DW), .SKIP_X0(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stall_req(sr1), .stall_ack(stall_ack),
    .rf_addr(ra1), .rf_rdata(rd1), .dump(if1), .busy(busy1), .done(done1), .abort(abort1)
  );

  // Views of the selected instance.
  logic          v_sr, v_busy, v_done, v_abort, v_valid, v_last;
  logic [AW-1:0] v_ra, v_addr;
  logic [DW-1:0] v_data;
  assign v_sr    = sel ? sr1 : sr0;
  assign v_busy  = sel ? busy1 : busy0;
  assign v_done  = sel ? done1 : done0;
  assign v_abort = sel ? abort1 : abort0;
  assign v_ra    = sel ? ra1 : ra0;
  assign v_valid = sel ? if1.dump_valid : if0.dump_valid;
  assign v_addr  = sel ? if1.dump_addr : if0.dump_addr;
  assign v_data  = sel ? if1.dump_data : if0.dump_data;
  assign v_last  = sel ? if1.dump_last : if0.dump_last;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_stall_req"}, 64'(v_sr), 64'd0);
    check({tag, "_rf_addr"},   64'(v_ra), 64'd0);
    check({tag, "_valid"},     64'(v_valid), 64'd0);
    check({tag, "_addr"},      64'(v_addr), 64'd0);
    check({tag, "_data"},      64'(v_data), 64'd0);
    check({tag, "_last"},      64'(v_last), 64'd0);
    check({tag, "_busy"},      64'(v_busy), 64'd0);
    check({tag, "_done"},      64'(v_done), 64'd0);
    check({tag, "_abort"},     64'(v_abort), 64'd0);
  endtask

  // One dump on the selected instance. rdy_mode: 0 ready=1, 1 random, 2 pattern 1-0-0-1.
  // abort_addr / rst_addr >= 0 inject the fault when that beat is presented.
  task automatic run_dump(input int ack_dly, input int rdy_mode, input int abort_addr,
                          input int rst_addr, input bit pulse_start);
    logic [AW-1:0] eq_addr [$];
    logic [DW-1:0] eq_data [$];
    logic [AW-1:0] h_addr, x_addr;
    logic [DW-1:0] h_data, x_data;
    logic          h_last;
    int first, nbeats, nstall, cyc, beats;
    bit held, finished, first_seen;
    first  = sel ? 1 : 0;
    nbeats = NREGS - first;
    nstall = 0; cyc = 0; beats = 0;
    held = 1'b0; finished = 1'b0; first_seen = 1'b0;
    h_addr = '0; h_data = '0; h_last = 1'b0;
    for (int i = first; i < NREGS; i++) begin
      eq_addr.push_back(AW'(i));
      eq_data.push_back(rf[i]);
    end
    stall_ack = 1'b0;
    ready     = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < ack_dly; k++) begin
      @(negedge clk);
      check("req_stall_req", 64'(v_sr), 64'd1);
      check("req_no_valid", 64'(v_valid), 64'd0);
      check("req_busy", 64'(v_busy), 64'd1);
      @(posedge clk); #1;
    end
    stall_ack = 1'b1;
    while (!finished && cyc < 3000) begin
      case (rdy_mode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      start = pulse_start && (cyc == 20);
      @(negedge clk);
      if (v_done) begin
        check("done_cycle", 64'(cyc), 64'(2 * nbeats + 1 + nstall));
        check("beat_count", 64'(beats), 64'(nbeats));
        check("queue_empty", 64'(eq_addr.size()), 64'd0);
        check("done_stall_req", 64'(v_sr), 64'd0);
        check("done_valid", 64'(v_valid), 64'd0);
        check("done_abort", 64'(v_abort), 64'd0);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("post_done_busy", 64'(v_busy), 64'd0);
          check("post_done_done", 64'(v_done), 64'd0);
          check("post_done_valid", 64'(v_valid), 64'd0);
        end
        finished = 1'b1;
      end else begin
        check("run_stall_req", 64'(v_sr), 64'd1);
        check("run_busy", 64'(v_busy), 64'd1);
        check("run_abort", 64'(v_abort), 64'd0);
        if (held) begin
          check("hold_valid", 64'(v_valid), 64'd1);
          check("hold_addr", 64'(v_addr), 64'(h_addr));
          check("hold_data", 64'(v_data), 64'(h_data));
          check("hold_last", 64'(v_last), 64'(h_last));
        end
        held = 1'b0;
        if (v_valid && !first_seen) begin
          first_seen = 1'b1;
          check("first_valid_cycle", 64'(cyc), 64'd2);
        end
        if (v_valid) begin
          check("rf_addr_in_send", 64'(v_ra), 64'(v_addr));
          if (abort_addr >= 0 && int'(v_addr) == abort_addr) begin
            stall_ack = 1'b0;
            ready     = 1'b0;
            start     = 1'b0;
            @(negedge clk);
            check("abort_pulse", 64'(v_abort), 64'd1);
            check("abort_stall_req", 64'(v_sr), 64'd0);
            check("abort_valid", 64'(v_valid), 64'd0);
            check("abort_no_done", 64'(v_done), 64'd0);
            @(negedge clk);
            check("after_abort_pulse", 64'(v_abort), 64'd0);
            check("after_abort_busy", 64'(v_busy), 64'd0);
            check("after_abort_done", 64'(v_done), 64'd0);
            finished = 1'b1;
          end else if (rst_addr >= 0 && int'(v_addr) == rst_addr) begin
            rst   = 1'b0;
            start = 1'b0;
            @(posedge clk); #1;
            check_idle("rst_mid");
            rst = 1'b1;
            @(negedge clk);
            check("rst_no_done", 64'(v_done), 64'd0);
            check("rst_no_abort", 64'(v_abort), 64'd0);
            finished = 1'b1;
          end else if (ready) begin
            if (eq_addr.size() == 0) begin
              check("extra_beat", 64'd1, 64'd0);
            end else begin
              x_addr = eq_addr.pop_front();
              x_data = eq_data.pop_front();
              check("beat_addr", 64'(v_addr), 64'(x_addr));
              check("beat_data", 64'(v_data), 64'(x_data));
              check("beat_last", 64'(v_last), 64'(int'(x_addr) == NREGS - 1));
            end
            beats++;
          end else begin
            held   = 1'b1;
            h_addr = v_addr;
            h_data = v_data;
            h_last = v_last;
            nstall++;
          end
        end
      end
      if (!finished) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    if (!finished) begin
      check("timeout", 64'd1, 64'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stall_ack = 1'b0; ready = 1'b0; sel = 1'b0;
    for (int i = 0; i < NREGS; i++) rf[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset0");
    sel = 1'b1; #1;
    check_idle("reset1");
    sel = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // All-ones registers behind a zero x0, ready tied high.
    rf[0] = 32'h0000_0000;
    for (int i = 1; i < NREGS; i++) rf[i] = 32'hFFFF_FFFF;
    run_dump(0, 0, -1, -1, 1'b0);

    // Ready pattern 1-0-0-1 with a known x5.
    for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
    rf[5] = 32'h1234_5678;
    run_dump(0, 2, -1, -1, 1'b0);

    // Acknowledge held off for 10 cycles.
    for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
    run_dump(10, 1, -1, -1, 1'b0);

    // Acknowledge lost during beat 7.
    run_dump(int'($urandom_range(0, 3)), 1, 7, -1, 1'b0);

    // x0 skipped, with a start pulse mid-dump.
    sel = 1'b1;
    for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
    run_dump(2, 1, -1, -1, 1'b1);

    // Reset during beat 12, then a fresh dump from address 0.
    sel = 1'b0;
    run_dump(1, 1, -1, 12, 1'b0);
    for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
    run_dump(0, 1, -1, -1, 1'b0);

    // Randomized dumps over both instances.
    for (int r = 0; r < 6; r++) begin
      sel = 1'($urandom_range(0, 1));
      for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
      run_dump(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), -1, -1,
               1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
